// File: rtl/sd_dac_pkg.sv
// Shared types and constants for the sigma-delta DAC sequencing controller.
package sd_dac_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RAMP_UP,
    ST_RUN,
    ST_RAMP_DOWN
  } dac_ctrl_state_t;

  localparam int UNDERRUN_W = 16;

  function automatic int midscale(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/sigma_delta_dac_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sigma_delta_dac_ctrl.sv
// Sequences the DAC code: pop-free ramps to/from midscale, round-robin sample
// forwarding in RUN, and a saturating underrun counter.
module sigma_delta_dac_ctrl
  import sd_dac_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DAC_BITLEN = 16,
  parameter int RAMP_STEP  = 256,
  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [NUM_SRC-1:0]              src_en,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*DAC_BITLEN-1:0]   src_data,
  output logic [NUM_SRC-1:0]              src_ready,
  input  logic                            dac_ready,
  output logic [DAC_BITLEN-1:0]           dac_input,
  output logic                            active,
  output logic [IDX_W-1:0]                last_src,
  input  logic                            clear_underrun,
  output logic [UNDERRUN_W-1:0]           underrun_cnt
);

  localparam int W1 = DAC_BITLEN + 1;
  localparam logic [W1-1:0] MID_X  = W1'(midscale(DAC_BITLEN));
  localparam logic [W1-1:0] STEP_X = W1'(RAMP_STEP);

  dac_ctrl_state_t          state_q, state_d;
  logic [DAC_BITLEN-1:0]    dac_q, dac_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [UNDERRUN_W-1:0]    cnt_q, cnt_d;
  logic                     active_q;

  logic [NUM_SRC-1:0]       grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_any;
  logic [DAC_BITLEN-1:0]    src_arr [NUM_SRC];

  logic [W1-1:0]            cur, up_sum, dn_diff, nxt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_arr[g] = src_data[g*DAC_BITLEN +: DAC_BITLEN];
  end

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req       (src_en & src_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Grant is only visible on a live RUN strobe; dropping enable suppresses it.
  assign src_ready = (dac_ready && enable && (state_q == ST_RUN)) ? grant : '0;

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cur     = {1'b0, dac_q};
    up_sum  = cur + STEP_X;
    dn_diff = cur - STEP_X;
    nxt     = cur;

    case (state_q)
      ST_OFF: begin
        dac_d = '0;
        if (enable) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!enable) begin
          state_d = ST_RAMP_DOWN;
        end else if (dac_ready) begin
          if (cur < MID_X)      nxt = (up_sum > MID_X) ? MID_X : up_sum;
          else if (cur > MID_X) nxt = (dn_diff < MID_X) ? MID_X : dn_diff;
          else                  nxt = MID_X;
          dac_d = nxt[DAC_BITLEN-1:0];
          if (nxt == MID_X) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_RAMP_DOWN;
        end else if (dac_ready) begin
          if (grant_any) begin
            dac_d  = src_arr[grant_idx];
            last_d = grant_idx;
            ptr_d  = (int'(grant_idx) == NUM_SRC - 1) ? '0 : IDX_W'(int'(grant_idx) + 1);
          end else if (cnt_q != {UNDERRUN_W{1'b1}}) begin
            cnt_d = cnt_q + UNDERRUN_W'(1);
          end
        end
      end
      ST_RAMP_DOWN: begin
        if (enable) begin
          state_d = ST_RAMP_UP;
        end else if (dac_ready) begin
          if (cur <= STEP_X) begin
            dac_d   = '0;
            state_d = ST_OFF;
          end else begin
            dac_d = dn_diff[DAC_BITLEN-1:0];
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (clear_underrun) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      dac_q    <= '0;
      ptr_q    <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      active_q <= (state_d == ST_RUN);
    end
  end

  assign dac_input    = dac_q;
  assign active       = active_q;
  assign last_src     = last_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_sigma_delta_dac_ctrl.sv
// Directed + random bench for sigma_delta_dac_ctrl against a per-cycle behavioural model.
module tb_sigma_delta_dac_ctrl;

  localparam int N    = 2;
  localparam int STEP = 256;
  localparam int MID  = 32768;
  localparam int M_OFF = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, enable = 1'b0, dac_ready = 1'b0, clear_underrun = 1'b0;
  logic [1:0]  src_en = 2'b00, src_valid = 2'b00;
  logic [15:0] sd [2];
  logic [31:0] src_data;
  logic [1:0]  src_ready;
  logic [15:0] dac_input;
  logic        active;
  logic [0:0]  last_src;
  logic [15:0] underrun_cnt;

  assign src_data = {sd[1], sd[0]};

  sigma_delta_dac_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .src_en         (src_en),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .dac_ready      (dac_ready),
    .dac_input      (dac_input),
    .active         (active),
    .last_src       (last_src),
    .clear_underrun (clear_underrun),
    .underrun_cnt   (underrun_cnt)
  );

  int total = 0, bad = 0;
  int m_mode, m_val, m_ptr, m_last, m_cnt;
  bit rand_data = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_val = 0; m_ptr = 0; m_last = 0; m_cnt = 0;
  endtask

  task automatic model_step(input int gi);
    if (rst) begin
      model_reset();
    end else begin
      case (m_mode)
        M_OFF: begin
          m_val = 0;
          if (enable) m_mode = M_UP;
        end
        M_UP: begin
          if (!enable) m_mode = M_DOWN;
          else if (dac_ready) begin
            if (m_val < MID)      m_val = (m_val + STEP > MID) ? MID : m_val + STEP;
            else if (m_val > MID) m_val = (m_val - STEP < MID) ? MID : m_val - STEP;
            if (m_val == MID) m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (!enable) m_mode = M_DOWN;
          else if (dac_ready) begin
            if (gi >= 0) begin
              m_val = int'(sd[gi]); m_last = gi; m_ptr = (gi + 1) % N;
            end else if (m_cnt < 65535) m_cnt++;
          end
        end
        default: begin
          if (enable) m_mode = M_UP;
          else if (dac_ready) begin
            if (m_val <= STEP) begin m_val = 0; m_mode = M_OFF; end
            else m_val = m_val - STEP;
          end
        end
      endcase
      if (clear_underrun) m_cnt = 0;
    end
  endtask

  // One clock: entered and left at a falling edge.
  task automatic cyc(input logic strobe);
    logic [1:0] exp_rdy;
    int gi;
    dac_ready = strobe;
    exp_rdy = 2'b00;
    gi = -1;
    if (m_mode == M_RUN && enable && strobe) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (gi < 0 && src_en[i] && src_valid[i]) gi = i;
      end
    end
    if (gi >= 0) exp_rdy[gi] = 1'b1;
    #1;
    chk("src_ready", 32'(src_ready), 32'(exp_rdy));
    @(posedge clk);
    model_step(gi);
    #1;
    chk("dac_input", 32'(dac_input), 32'(m_val));
    chk("active", 32'(active), 32'(m_mode == M_RUN));
    chk("last_src", 32'(last_src), 32'(m_last));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    @(negedge clk);
    if (gi >= 0 && rand_data) sd[gi] = 16'($urandom);
  endtask

  task automatic ramp_to_run(input int period, output int n);
    n = 0;
    for (int c = 0; c < 5000 && !active; c++) begin
      cyc(c % period == period - 1);
      if (c % period == period - 1) n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    sd[0] = 16'h0; sd[1] = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dac", 32'(dac_input), 32'h0);
    chk("rst_ready", 32'(src_ready), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_last", 32'(last_src), 32'h0);
    chk("rst_cnt", 32'(underrun_cnt), 32'h0);
    rst = 1'b0;

    // Startup ramp: 0, 256, ... 32768
    enable = 1'b1;
    ramp_to_run(4, n);
    chk("ramp_strobes", 32'(n), 32'd128);
    chk("ramp_mid", 32'(dac_input), 32'h8000);

    // Round robin with fixed data
    src_en = 2'b11; src_valid = 2'b11; sd[0] = 16'h1000; sd[1] = 16'h2000;
    for (int s = 0; s < 8; s++) begin
      cyc(1'b1);
      chk("rr_data", 32'(dac_input), (s % 2 == 0) ? 32'h1000 : 32'h2000);
      cyc(1'b0);
    end

    // Random traffic in RUN
    rand_data = 1'b1;
    for (int c = 0; c < 300; c++) begin
      src_en = 2'($urandom); src_valid = 2'($urandom);
      for (int i = 0; i < N; i++) if (!src_valid[i]) sd[i] = 16'($urandom);
      cyc($urandom_range(0, 2) == 0);
    end

    // Masked source: underruns, held output
    src_en = 2'b01; src_valid = 2'b10;
    for (int s = 0; s < 5; s++) cyc(1'b1);
    while (m_cnt < 65534) cyc(1'b1);
    chk("cnt_fffe", 32'(underrun_cnt), 32'hFFFE);
    repeat (3) cyc(1'b1);
    chk("cnt_sat", 32'(underrun_cnt), 32'hFFFF);
    clear_underrun = 1'b1;
    cyc(1'b1);
    clear_underrun = 1'b0;
    chk("cnt_clear", 32'(underrun_cnt), 32'h0);

    // Shutdown from 0x0150
    rand_data = 1'b0;
    src_en = 2'b01; src_valid = 2'b01; sd[0] = 16'h0150;
    cyc(1'b1);
    chk("sd_load", 32'(dac_input), 32'h0150);
    enable = 1'b0;
    cyc(1'b1);
    chk("sd_hold", 32'(dac_input), 32'h0150);
    cyc(1'b1);
    chk("sd_step", 32'(dac_input), 32'h0050);
    cyc(1'b1);
    chk("sd_zero", 32'(dac_input), 32'h0);
    cyc(1'b0);
    chk("sd_off", 32'(active), 32'h0);

    // Re-enable during ramp-down from 0xC000
    src_valid = 2'b00;
    enable = 1'b1;
    ramp_to_run(1, n);
    src_valid = 2'b01; sd[0] = 16'hC000;
    cyc(1'b1);
    chk("re_load", 32'(dac_input), 32'hC000);
    src_valid = 2'b00;
    enable = 1'b0;
    cyc(1'b0);
    enable = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    chk("re_first", 32'(dac_input), 32'hBF00);
    ramp_to_run(2, n);
    chk("re_strobes", 32'(n + 1), 32'd64);
    chk("re_mid", 32'(dac_input), 32'h8000);

    // Reset mid-RUN after moving the pointer to src1
    src_en = 2'b11; src_valid = 2'b01; sd[0] = 16'h1234;
    cyc(1'b1);
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    chk("mr_dac", 32'(dac_input), 32'h0);
    chk("mr_active", 32'(active), 32'h0);
    chk("mr_last", 32'(last_src), 32'h0);
    chk("mr_cnt", 32'(underrun_cnt), 32'h0);
    src_valid = 2'b00;
    ramp_to_run(1, n);
    src_valid = 2'b11; sd[0] = 16'h0A0A; sd[1] = 16'hB0B0;
    cyc(1'b1);
    chk("mr_first_grant", 32'(last_src), 32'h0);
    chk("mr_first_data", 32'(dac_input), 32'h0A0A);

    // Random mix of enable toggles, clears and resets
    rand_data = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      rst = ($urandom_range(0, 699) == 0);
      clear_underrun = ($urandom_range(0, 39) == 0);
      src_en = 2'($urandom); src_valid = 2'($urandom);
      for (int i = 0; i < N; i++) if (!src_valid[i]) sd[i] = 16'($urandom);
      cyc($urandom_range(0, 1) == 0);
    end
    rst = 1'b0; clear_underrun = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
